// File: rtl/multi_flop_sync_filter_pkg.sv
// Shared constants and helpers for the multi-channel sync/debounce/edge conditioner.
package multi_flop_sync_filter_pkg;

  localparam int MIN_STAGES        = 2;
  localparam int MIN_FILTER_CYCLES = 1;

  // Counter must hold 0..FILTER_CYCLES-1; one extra code keeps FILTER_CYCLES=1 at 1 bit.
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/multi_flop_sync_filter_channel.sv
// One channel of stability filter plus edge detector, fed from the synchronised level.
module sync_filter_channel
  import multi_flop_sync_filter_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_rst_n,
  input  logic sync_in,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_next
);

  localparam int              CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             differ;
  logic             accept;
  logic             filt_next;
  logic             rise_next;
  logic             fall_next;

  // Accept happens on the edge closing the FILTER_CYCLES-th differing cycle;
  // any return to equality clears the count, so it can never pass CNT_LAST.
  always_comb begin
    differ    = (sync_in != filt_out);
    accept    = differ && (cnt == CNT_LAST);
    cnt_next  = '0;
    if (differ && !accept) cnt_next = cnt + CNT_W'(1);
    filt_next = accept ? sync_in : filt_out;
    rise_next = accept & sync_in;
    fall_next = accept & ~sync_in;
  end

  assign change_next = accept;

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      cnt        <= '0;
      filt_out   <= RESET_VALUE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      filt_out   <= filt_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
    end
  end

endmodule

// File: rtl/multi_flop_sync_filter.sv
// Multi-channel async input conditioner: flop synchroniser, debounce filter, edge pulses.
module multi_flop_sync_filter
  import multi_flop_sync_filter_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  NUM_STAGES    = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                dest_clk,
  input  logic                dest_rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] filt_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
    $error("multi_flop_sync_filter: NUM_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
    $error("multi_flop_sync_filter: FILTER_CYCLES must be >= 1");
  end

  // Plain flop chain, nothing between stages, so the tool can place it as a synchroniser.
  logic [CHANNELS-1:0] stage [NUM_STAGES];

  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) stage[k] <= RESET_VALUE;
    end else begin
      stage[0] <= async_in;
      for (int k = 1; k < NUM_STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  assign sync_out = stage[NUM_STAGES-1];

  logic [CHANNELS-1:0] change_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filter_channel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_chan (
      .dest_clk    (dest_clk),
      .dest_rst_n  (dest_rst_n),
      .sync_in     (sync_out[i]),
      .filt_out    (filt_out[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .change_next (change_next[i])
    );
  end

  // Built from the channels' next-state accept so it lands on the same edge as the pulses.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) any_change <= 1'b0;
    else             any_change <= |change_next;
  end

endmodule

// File: tb/tb_multi_flop_sync_filter.sv
// Directed bench for multi_flop_sync_filter: default build plus a NUM_STAGES=3, FILTER_CYCLES=1 build.
module tb_multi_flop_sync_filter;

  logic       dest_clk = 1'b0;
  logic       dest_rst_n = 1'b0;
  logic [3:0] async_in = 4'h0;

  logic [3:0] sync_a, filt_a, rise_a, fall_a;
  logic       any_a;
  logic [3:0] sync_b, filt_b, rise_b, fall_b;
  logic       any_b;

  int checks   = 0;
  int failures = 0;

  always #5 dest_clk = ~dest_clk;

  multi_flop_sync_filter dut_a (
    .dest_clk   (dest_clk),
    .dest_rst_n (dest_rst_n),
    .async_in   (async_in),
    .sync_out   (sync_a),
    .filt_out   (filt_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .any_change (any_a)
  );

  multi_flop_sync_filter #(
    .NUM_STAGES    (3),
    .FILTER_CYCLES (1)
  ) dut_b (
    .dest_clk   (dest_clk),
    .dest_rst_n (dest_rst_n),
    .async_in   (async_in),
    .sync_out   (sync_b),
    .filt_out   (filt_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .any_change (any_b)
  );

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    async_in   = v;
    dest_rst_n = 1'b0;
    tick();
    tick();
    @(negedge dest_clk);
    dest_rst_n = 1'b1;
    repeat (12) tick();
  endtask

  // {sync, filt, rise, fall, any}
  task automatic test_reset();
    logic [16:0] exp_v;
    logic [16:0] act_v;
    async_in   = 4'hF;
    dest_rst_n = 1'b0;
    tick();
    tick();
    act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
    checks++;
    if (act_v !== 17'h0) begin
      failures++;
      $display("FAIL reset_hold_a actual=%h required=%h", act_v, 17'h0);
    end
    act_v = {sync_b, filt_b, rise_b, fall_b, any_b};
    checks++;
    if (act_v !== 17'h0) begin
      failures++;
      $display("FAIL reset_hold_b actual=%h required=%h", act_v, 17'h0);
    end
    @(negedge dest_clk);
    dest_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {(k >= 2) ? 4'hF : 4'h0, (k >= 6) ? 4'hF : 4'h0,
               (k == 6) ? 4'hF : 4'h0, 4'h0, (k == 6)};
      act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL reset_release edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [16:0] exp_v;
    logic [16:0] act_v;
    do_reset(4'h0);
    async_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {(k >= 2) ? 4'h1 : 4'h0, (k >= 6) ? 4'h1 : 4'h0,
               (k == 6) ? 4'h1 : 4'h0, 4'h0, (k == 6)};
      act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL clean_step edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] act_v;
    logic [8:0]  exp_s;
    logic [8:0]  act_s;
    do_reset(4'h0);
    async_in = 4'b0010;
    repeat (3) tick();
    async_in = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      act_v = {filt_a, rise_a, fall_a, any_a};
      checks++;
      if (act_v !== 13'h0) begin
        failures++;
        $display("FAIL glitch edge=%0d actual=%h required=%h", k, act_v, 13'h0);
      end
    end
    // A fresh step must still need the full qualification, proving the count was cleared.
    async_in = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_s = {(k >= 6) ? 4'h2 : 4'h0, (k == 6) ? 4'h2 : 4'h0, (k == 6)};
      act_s = {filt_a, rise_a, any_a};
      checks++;
      if (act_s !== exp_s) begin
        failures++;
        $display("FAIL glitch_recount edge=%0d actual=%h required=%h", k, act_s, exp_s);
      end
    end
  endtask

  task automatic test_chatter();
    logic [7:0] exp_v;
    logic [7:0] act_v;
    int         rise_count;
    rise_count = 0;
    do_reset(4'h0);
    async_in = 4'b0100;
    repeat (3) tick();
    async_in = 4'b0000;
    tick();
    async_in = 4'b0100;
    // Final rising sync_out is at edge 6, so filt_out follows at edge 10.
    for (int k = 5; k <= 16; k++) begin
      tick();
      if (rise_a[2]) rise_count++;
      exp_v = {(k >= 10) ? 4'h4 : 4'h0, (k == 10) ? 4'h4 : 4'h0};
      act_v = {filt_a, rise_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL chatter edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
    end
    checks++;
    if (rise_count != 1) begin
      failures++;
      $display("FAIL chatter_pulse_count actual=%0d required=1", rise_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] exp_v;
    logic [12:0] act_v;
    do_reset(4'b1000);
    async_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {(k >= 6) ? 4'h1 : 4'h8, (k == 6) ? 4'h1 : 4'h0,
               (k == 6) ? 4'h8 : 4'h0, (k == 6)};
      act_v = {filt_a, rise_a, fall_a, any_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL simultaneous edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [16:0] exp_v;
    logic [16:0] act_v;
    do_reset(4'h0);
    async_in = 4'b0001;
    repeat (4) tick();
    act_v = {12'h0, filt_b, rise_b[0]};
    checks++;
    if (act_v !== {12'h0, 4'h1, 1'b1}) begin
      failures++;
      $display("FAIL b_qualify_before_reset actual=%h required=%h", act_v, {12'h0, 4'h1, 1'b1});
    end
    act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
    checks++;
    if (act_v !== {4'h1, 13'h0}) begin
      failures++;
      $display("FAIL a_mid_count actual=%h required=%h", act_v, {4'h1, 13'h0});
    end
    dest_rst_n = 1'b0;
    #1;
    act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
    checks++;
    if (act_v !== 17'h0) begin
      failures++;
      $display("FAIL mid_reset_a actual=%h required=%h", act_v, 17'h0);
    end
    act_v = {sync_b, filt_b, rise_b, fall_b, any_b};
    checks++;
    if (act_v !== 17'h0) begin
      failures++;
      $display("FAIL mid_reset_b actual=%h required=%h", act_v, 17'h0);
    end
    tick();
    tick();
    @(negedge dest_clk);
    dest_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {(k >= 2) ? 4'h1 : 4'h0, (k >= 6) ? 4'h1 : 4'h0,
               (k == 6) ? 4'h1 : 4'h0, 4'h0, (k == 6)};
      act_v = {sync_a, filt_a, rise_a, fall_a, any_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL mid_release_a edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
      exp_v = {(k >= 3) ? 4'h1 : 4'h0, (k >= 4) ? 4'h1 : 4'h0,
               (k == 4) ? 4'h1 : 4'h0, 4'h0, (k == 4)};
      act_v = {sync_b, filt_b, rise_b, fall_b, any_b};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL mid_release_b edge=%0d actual=%h required=%h", k, act_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
